mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Multi-cycle iterative multiply/divide unit with architectural HI/LO registers.
- Sits beside the combinational ALU in the EX stage of the pipelined MIPS core and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Replaces the combinational multiply/divide path with a parametrised radix-2 sequential datapath.
- Uses a start/busy/done handshake so the hazard unit can stall mfhi/mflo and new mult/div operations while the unit is busy.

Parameters:
- WIDTH, default 32: operand width; HI and LO are WIDTH bits each; iteration count = WIDTH.
- CNT_W, default $clog2(WIDTH)+1: width of the iteration counter (derived; do not override).

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op  in  2  operation, sampled with start: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand (multiplicand/dividend).
- b  in  WIDTH  rt operand (multiplier/divisor).
- hi_we  in  1  MTHI write strobe.
- lo_we  in  1  MTLO write strobe.
- wdata  in  WIDTH  data for MTHI/MTLO.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  sticky until next start; set when a DIV/DIVU completes with b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset_n low at an edge): state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; counter and iteration registers cleared. Reset mid-operation aborts the operation with no HI/LO update.
- FSM states and transitions:
  - IDLE: on start, latch op, |a|, |b| (magnitudes only for signed ops) and the result signs; clear counter; go to CALC.
  - CALC: one iteration per cycle for WIDTH cycles. Multiply is shift-add into a 2*WIDTH product. Divide is restoring shift-subtract, producing quotient and remainder. After the WIDTH-th iteration go to FIX.
  - FIX: sign correction, then write HI/LO at the end of this cycle; go to IDLE.
- Sign rules:
  - Product negated if the operand signs differ.
  - Quotient negated if the signs differ; remainder takes the dividend's sign.
  - MULTU/DIVU: no correction.
- Result mapping: multiply hi=product[2W-1:W], lo=product[W-1:0]; divide lo=quotient, hi=remainder.
- Timing:
  - done is registered and high for exactly one cycle, WIDTH+2 edges after the start edge; HI/LO carry the new values in that same cycle.
  - busy is high from the edge after start through FIX and is low when done is high.
  - A new start is accepted in the done cycle (back-to-back operation).
- start while busy: ignored, not queued.
- Divide by zero: fixed latency still applies; lo = all ones, hi = a (unconverted); div_by_zero=1.
- Signed overflow: INT_MIN / -1 gives lo=INT_MIN, hi=0 with no flag; this falls out of the magnitude algorithm.
- MTHI/MTLO:
  - Writes in IDLE take effect at the next edge.
  - A write together with start in the same cycle is applied, and the operation result later overwrites it.
  - Writes while busy are dropped.

Optional Feature:
- Macro: MUL_DIV_EARLY_OUT_EN.
- Defined: if a==0 or b==0 at start, skip CALC and go IDLE->FIX. done then arrives 2 edges after start, with results identical to the full path (including the divide-by-zero values and flag).
- Undefined: fixed WIDTH+2 latency for every operand.

Decomposition:
- Package mul_div_pkg holds:
  - typedef enum logic[1:0] md_op_t {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  - typedef enum logic[1:0] md_state_t {MD_IDLE, MD_CALC, MD_FIX};
  - the default WIDTH constant.
- One natural sub-module, md_iter_core: unsigned one-step-per-cycle shift-add/shift-subtract datapath with a mode input. The top level owns the FSM, sign handling, handshake and HI/LO.

Test Plan (WIDTH=32):
- MULT a=-3 (FFFFFFFD), b=7 -> done exactly 34 edges after start; hi=FFFFFFFF, lo=FFFFFFEB; busy low during done.
- MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. Start asserted again mid-operation -> ignored, single done pulse.
- DIV a=-7, b=2 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). DIVU a=100, b=7 issued in the done cycle -> lo=0000000E, hi=00000002.
- DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0, div_by_zero=0. DIVU a=5, b=0 -> lo=FFFFFFFF, hi=5, div_by_zero=1 until the next start.
- MTHI wdata=1234 in IDLE -> hi=1234 next cycle. MTLO during busy -> lo unchanged by the write. reset_n low at CALC cycle 10 -> next cycle busy=0, done=0, hi=lo=0, and no done pulse follows.
- With MUL_DIV_EARLY_OUT_EN: MULT a=0, b=9 -> done 2 edges after start, hi=lo=0. Without the macro, the same stimulus gives done at 34 edges.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types and defaults for the iterative multiply/divide unit.
package mul_div_pkg;

  localparam int unsigned MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Unsigned radix-2 datapath: one shift-add (multiply) or restoring
// shift-subtract (divide) step per enabled cycle.
// Multiply: {o_hi,o_lo} = product. Divide: o_lo = quotient, o_hi = remainder.
module md_iter_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic             r_div;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opd;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // Step arithmetic for both modes.
  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opd} : '0);
    w_shift = {r_hi, r_lo[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, r_opd});
    w_diff  = WIDTH'(w_shift - {1'b0, r_opd});
  end

  // Operand load and per-cycle iteration.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_div <= 1'b0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_opd <= '0;
    end else if (i_load) begin
      r_div <= i_div;
      r_hi  <= '0;
      r_lo  <= i_div ? i_a : i_b;
      r_opd <= i_div ? i_b : i_a;
    end else if (i_step) begin
      if (r_div) begin
        r_hi <= w_ge ? w_diff : w_shift[WIDTH-1:0];
        r_lo <= {r_lo[WIDTH-2:0], w_ge};
      end else begin
        r_hi <= w_sum[WIDTH:1];
        r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional MUL_DIV_EARLY_OUT_EN: zero operand skips the iteration phase.
module mul_div_unit
  import mul_div_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t        r_state, w_state_nxt;
  md_op_t           r_op;
  logic             r_neg_q, r_neg_r, r_b_zero, r_skip;
  logic [WIDTH-1:0] r_a_raw;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy, r_done, r_dbz;
  logic [WIDTH-1:0] r_hi, r_lo;

  md_op_t           w_op;
  logic             w_signed, w_a_neg, w_b_neg, w_is_div, w_r_is_div, w_skip;
  logic             w_accept, w_step, w_fix;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_core_hi, w_core_lo, w_res_hi, w_res_lo;
  logic [2*WIDTH-1:0] w_prod;

  assign w_op       = md_op_t'(op);
  assign w_signed   = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_is_div   = (w_op == MD_DIV) || (w_op == MD_DIVU);
  assign w_r_is_div = (r_op == MD_DIV) || (r_op == MD_DIVU);
  assign w_a_neg    = w_signed & a[WIDTH-1];
  assign w_b_neg    = w_signed & b[WIDTH-1];
  assign w_a_mag    = w_a_neg ? -a : a;
  assign w_b_mag    = w_b_neg ? -b : b;

`ifdef MUL_DIV_EARLY_OUT_EN
  assign w_skip = (a == '0) || (b == '0);
`else
  assign w_skip = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= MD_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and phase strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_fix       = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = w_skip ? MD_FIX : MD_CALC;
        end
      end
      MD_CALC: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = MD_FIX;
      end
      MD_FIX: begin
        w_fix       = 1'b1;
        w_state_nxt = MD_IDLE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_accept),
    .i_step  (w_step),
    .i_div   (w_is_div),
    .i_a     (w_a_mag),
    .i_b     (w_b_mag),
    .o_hi    (w_core_hi),
    .o_lo    (w_core_lo)
  );

  // Sign correction and HI/LO mapping, including divide-by-zero values.
  always_comb begin
    w_prod = r_skip ? '0 : {w_core_hi, w_core_lo};
    if (r_neg_q) w_prod = -w_prod;
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    if (w_r_is_div) begin
      if (r_b_zero) begin
        w_res_hi = r_a_raw;
        w_res_lo = '1;
      end else begin
        w_res_hi = r_neg_r ? -w_core_hi : w_core_hi;
        w_res_lo = r_neg_q ? -w_core_lo : w_core_lo;
      end
    end
  end

  // Operation context, counter, handshake, flag and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_op     <= MD_MULT;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_b_zero <= 1'b0;
      r_skip   <= 1'b0;
      r_a_raw  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_busy <= (w_state_nxt != MD_IDLE);
      r_done <= w_fix;
      if (w_accept) begin
        r_op     <= w_op;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_b_zero <= (b == '0);
        r_skip   <= w_skip;
        r_a_raw  <= a;
        r_cnt    <= '0;
        r_dbz    <= 1'b0;
      end else begin
        if (w_step) r_cnt <= r_cnt + CNT_W'(1);
        if (w_fix && w_r_is_div && r_b_zero) r_dbz <= 1'b1;
      end
      if (w_fix) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (r_state == MD_IDLE) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit against an arithmetic reference model.
module tb_mul_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset_n, start, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] a, b, wdata;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma, input logic [31:0] mb);
    longint sa, sb, q, r;
    logic [63:0] res;
    res = '0;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    case (mop)
      2'd0: res = 64'(sa * sb);
      2'd1: res = {32'd0, ma} * {32'd0, mb};
      2'd2: begin
        if (mb == 0) res = {ma, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (mb == 0) res = {ma, 32'hFFFF_FFFF};
        else res = {ma % mb, ma / mb};
      end
    endcase
    return res;
  endfunction

  function automatic int lat_for(input logic [31:0] x, input logic [31:0] y);
`ifdef MUL_DIV_EARLY_OUT_EN
    if (x == 0 || y == 0) return 2;
`endif
    return W + 2;
  endfunction

  // Issue one operation and wait for done; returns in the done cycle.
  // poke_at > 0 re-asserts start (with a changed operand) at that edge count.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int poke_at, input string tag);
    logic [63:0] exp;
    int n;
    bit seen;
    exp = model(o, x, y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    chk({tag, " busy_after_start"}, 64'(busy), 64'(1));
    chk({tag, " dbz_cleared"}, 64'(div_by_zero), 64'(0));
    seen = (done === 1'b1);
    while (!seen && n < 200) begin
      start = (n == poke_at);
      if (n == poke_at) a = ~a;
      tick();
      n++;
      if (done === 1'b1) seen = 1'b1;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(lat_for(x, y)));
    chk({tag, " busy_in_done"}, 64'(busy), 64'(0));
    chk({tag, " hi"}, 64'(hi), 64'(exp[63:32]));
    chk({tag, " lo"}, 64'(lo), 64'(exp[31:0]));
    chk({tag, " dbz"}, 64'(div_by_zero), 64'(o[1] && (y == 0)));
  endtask

  initial begin
    logic [31:0] lo_before, x, y;
    logic [63:0] exp;
    logic [1:0]  o;
    int n;
    bit seen;

    reset_n = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'b00; a = '0; b = '0; wdata = '0;
    tick(); tick();
    chk("rst busy", 64'(busy), 64'(0));
    chk("rst done", 64'(done), 64'(0));
    chk("rst dbz", 64'(div_by_zero), 64'(0));
    chk("rst hi", 64'(hi), 64'(0));
    chk("rst lo", 64'(lo), 64'(0));
    reset_n = 1'b1;
    tick();

    // Directed cases, chained back-to-back where noted.
    do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, "mult_neg3x7");
    tick();
    chk("single_done_pulse", 64'(done), 64'(0));
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 12, "multu_max");
    tick();
    chk("poke_no_second_done", 64'(done), 64'(0));
    do_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_neg7by2");
    do_op(2'b11, 32'd100, 32'd7, 0, "divu_100by7");
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_intmin");
    do_op(2'b11, 32'd5, 32'd0, 0, "divu_by0");
    repeat (3) tick();
    chk("dbz_sticky", 64'(div_by_zero), 64'(1));
    do_op(2'b10, 32'hFFFF_FFF0, 32'd0, 0, "div_neg_by0");
    do_op(2'b00, 32'd0, 32'd9, 0, "mult_zero");
    do_op(2'b10, 32'd0, 32'd3, 0, "div_zero_dividend");

    // MTHI in idle.
    tick();
    hi_we = 1'b1; wdata = 32'd1234;
    tick();
    hi_we = 1'b0;
    chk("mthi_idle", 64'(hi), 64'(1234));

    // MTHI together with start, then MTLO while busy.
    x = 32'h0001_2345; y = 32'h0000_0777;
    exp = model(2'b01, x, y);
    lo_before = lo;
    op = 2'b01; a = x; b = y; start = 1'b1; hi_we = 1'b1; wdata = 32'h0000_5A5A;
    tick();
    start = 1'b0; hi_we = 1'b0;
    chk("mthi_with_start", 64'(hi), 64'(32'h0000_5A5A));
    lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    lo_we = 1'b0;
    chk("mtlo_busy_dropped", 64'(lo), 64'(lo_before));
    n = 2;
    while (done !== 1'b1 && n < 200) begin tick(); n++; end
    chk("mtlo_op latency", 64'(n), 64'(W + 2));
    chk("mtlo_op hi", 64'(hi), 64'(exp[63:32]));
    chk("mtlo_op lo", 64'(lo), 64'(exp[31:0]));

    // Randomized operations, alternating back-to-back and idle gaps.
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      x = $urandom();
      y = $urandom();
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: x = 32'd0;
        2: y = 32'($urandom_range(1, 15));
        3: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: ;
      endcase
      do_op(o, x, y, (i % 5 == 0) ? 7 : 0, $sformatf("rand%0d", i));
      if (i % 3 == 0) repeat ($urandom_range(1, 3)) tick();
    end

    // Reset in the middle of CALC aborts with no later done.
    tick();
    op = 2'b01; a = 32'h1357_9BDF; b = 32'h2468_ACE0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    reset_n = 1'b0;
    tick();
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    chk("midrst hi", 64'(hi), 64'(0));
    chk("midrst lo", 64'(lo), 64'(0));
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
    end
    chk("midrst no_done", 64'(seen), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
